// File: rtl/equation_checker.sv
// equation_checker: timer-target puzzle checker with a 4-step ALU schedule.
// Clock/Resetn, Start/Go/Mode/OngoingTimer/DataIn in; Busy/Correct/Failed/DivErr/TriesLeft/Result out.
module equation_checker #(
    parameter int WIDTH       = 8,
    parameter int TIMER_WIDTH = 7,
    parameter int MAX_TRIES   = 3
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic                           Start,
    input  logic                           Go,
    input  logic [1:0]                     Mode,
    input  logic [TIMER_WIDTH-1:0]         OngoingTimer,
    input  logic [WIDTH-1:0]               DataIn,
    output logic                           Busy,
    output logic                           Correct,
    output logic                           Failed,
    output logic                           DivErr,
    output logic [$clog2(MAX_TRIES+1)-1:0] TriesLeft,
    output logic [WIDTH-1:0]               Result
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_X, WAIT_X, LOAD_Y, WAIT_Y,
        LOAD_Z, WAIT_Z, CALC_0, CALC_1, CALC_2,
        CALC_3, COMPARE, COMPLETE, FAILED
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] x, y, z;
    logic [WIDTH-1:0] t1, t2, r;
    logic [WIDTH-1:0] target;
    logic [1:0]       mode_q;
    logic             abort;
    logic             hit;
    logic             last_try;

    // Divide by zero returns 0; the caller flags DivErr.
    function automatic logic [WIDTH-1:0] udiv(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return (b == '0) ? '0 : a / b;
    endfunction

    assign Busy     = !(state inside {IDLE, COMPLETE, FAILED});
    assign Correct  = (state == COMPLETE);
    assign Failed   = (state == FAILED);
    assign abort    = Busy && !Start;
    assign hit      = (r == target) && !DivErr;
    assign last_try = (TriesLeft == TW'(1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (Start) state_nxt = LOAD_X;
                LOAD_X:   if (Go)    state_nxt = WAIT_X;
                WAIT_X:   if (!Go)   state_nxt = LOAD_Y;
                LOAD_Y:   if (Go)    state_nxt = WAIT_Y;
                WAIT_Y:   if (!Go)   state_nxt = LOAD_Z;
                LOAD_Z:   if (Go)    state_nxt = WAIT_Z;
                WAIT_Z:   if (!Go)   state_nxt = CALC_0;
                CALC_0:   state_nxt = CALC_1;
                CALC_1:   state_nxt = CALC_2;
                CALC_2:   state_nxt = CALC_3;
                CALC_3:   state_nxt = COMPARE;
                COMPARE: begin
                    if (hit)           state_nxt = COMPLETE;
                    else if (last_try) state_nxt = FAILED;
                    else               state_nxt = LOAD_X;
                end
                COMPLETE: if (!Start) state_nxt = IDLE;
                FAILED:   if (!Start) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            t1        <= '0;
            t2        <= '0;
            r         <= '0;
            target    <= '0;
            mode_q    <= '0;
            DivErr    <= 1'b0;
            TriesLeft <= '0;
            Result    <= '0;
        end else if (abort) begin
            DivErr <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    target    <= WIDTH'(OngoingTimer);
                    mode_q    <= Mode;
                    TriesLeft <= TW'(MAX_TRIES);
                    DivErr    <= 1'b0;
                end
                LOAD_X: if (Go) x <= DataIn;
                LOAD_Y: if (Go) y <= DataIn;
                LOAD_Z: if (Go) z <= DataIn;
                CALC_0: begin
                    unique case (mode_q)
                        2'd0: begin
                            t1 <= udiv(x, z);
                            if (z == '0) DivErr <= 1'b1;
                        end
                        2'd1: t1 <= x * y;
                        2'd2: t1 <= x + y;
                        2'd3: t1 <= x * x;
                    endcase
                end
                CALC_1: begin
                    unique case (mode_q)
                        2'd0: t1 <= t1 * t1;
                        2'd1: r  <= t1 - z;
                        2'd2: r  <= t1 * z;
                        2'd3: t2 <= y * z;
                    endcase
                end
                CALC_2: begin
                    case (mode_q)
                        2'd0: begin
                            t2 <= udiv(y, z);
                            if (z == '0) DivErr <= 1'b1;
                        end
                        2'd3:    r <= t1 + t2;
                        default: ;
                    endcase
                end
                CALC_3: if (mode_q == 2'd0) r <= t1 + t2;
                COMPARE: begin
                    Result <= r;
                    if (!hit) TriesLeft <= TriesLeft - TW'(1);
                    // Retry starts a fresh attempt in LOAD_X.
                    if (!hit && !last_try) DivErr <= 1'b0;
                end
                COMPLETE, FAILED: if (!Start) DivErr <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_equation_checker.sv
// tb_equation_checker: directed plus randomized rounds against an
// arithmetic reference model of the four equations.
module tb_equation_checker;

    localparam int MOD = 256;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       Go = 1'b0;
    logic [1:0] Mode = 2'd0;
    logic [6:0] OngoingTimer = 7'd0;
    logic [7:0] DataIn = 8'd0;
    logic       Busy, Correct, Failed, DivErr;
    logic [1:0] TriesLeft;
    logic [7:0] Result;

    int total = 0;
    int bad   = 0;

    equation_checker dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Go(Go),
        .Mode(Mode), .OngoingTimer(OngoingTimer), .DataIn(DataIn),
        .Busy(Busy), .Correct(Correct), .Failed(Failed),
        .DivErr(DivErr), .TriesLeft(TriesLeft), .Result(Result)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void ref_eval(input int m, input int x,
                                     input int y, input int z,
                                     output int r, output bit de);
        int a, b;
        de = 1'b0;
        case (m)
            0: begin
                de = (z == 0);
                a  = de ? 0 : x / z;
                a  = (a * a) % MOD;
                b  = de ? 0 : y / z;
                r  = (a + b) % MOD;
            end
            1: r = ((x * y) % MOD - z + MOD) % MOD;
            2: r = (((x + y) % MOD) * z) % MOD;
            default: r = ((x * x) % MOD + (y * z) % MOD) % MOD;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_round(input int m, input int t);
        Mode = 2'(m);
        OngoingTimer = 7'(t);
        Start = 1'b1;
        tick();
    endtask

    task automatic end_round();
        Start = 1'b0;
        tick();
    endtask

    task automatic press(input int v);
        DataIn = 8'(v);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        tick();
    endtask

    // Returns DivErr and Correct as seen in COMPARE, then steps to outcome.
    task automatic attempt(input int x, input int y, input int z,
                           output logic de_c, output logic co_c);
        press(x);
        press(y);
        press(z);
        repeat (4) tick();
        de_c = DivErr;
        co_c = Correct;
        tick();
    endtask

    initial begin
        int x, y, z, r, tgt, tries, last_res;
        bit de, ok;
        logic dc, cc;

        #12;
        check("rst_busy", Busy, 0);
        check("rst_correct", Correct, 0);
        check("rst_failed", Failed, 0);
        check("rst_diverr", DivErr, 0);
        check("rst_tries", TriesLeft, 0);
        check("rst_result", Result, 0);
        Resetn = 1'b1;
        tick();
        check("rst_idle", Busy, 0);

        start_round(0, 22);
        check("m0_busy", Busy, 1);
        check("m0_tries", TriesLeft, 3);
        attempt(8, 12, 2, dc, cc);
        check("m0_early", cc, 0);
        check("m0_correct", Correct, 1);
        check("m0_result", Result, 22);
        check("m0_tries_kept", TriesLeft, 3);
        check("m0_diverr", DivErr, 0);
        tick();
        check("m0_hold", Correct, 1);
        end_round();
        check("m0_drop", Correct, 0);
        check("m0_idle", Busy, 0);

        start_round(1, 100);
        attempt(20, 20, 10, dc, cc);
        check("m1_miss", Correct, 0);
        check("m1_busy", Busy, 1);
        check("m1_tries", TriesLeft, 2);
        check("m1_result", Result, 134);
        attempt(11, 10, 10, dc, cc);
        check("m1_retry", Correct, 1);
        check("m1_res2", Result, 100);
        check("m1_tries2", TriesLeft, 2);
        end_round();

        start_round(2, 0);
        attempt(200, 100, 3, dc, cc);
        check("m2_result", Result, 132);
        end_round();
        check("m2_abort_tries", TriesLeft, 2);
        start_round(3, 120);
        attempt(10, 5, 4, dc, cc);
        check("m3_result", Result, 120);
        check("m3_correct", Correct, 1);
        end_round();

        start_round(0, 0);
        attempt(5, 5, 0, dc, cc);
        check("dz_flag", dc, 1);
        check("dz_wrong", Correct, 0);
        check("dz_result", Result, 0);
        check("dz_tries", TriesLeft, 2);
        check("dz_clear", DivErr, 0);
        end_round();

        start_round(1, 1);
        repeat (3) attempt(1, 1, 1, dc, cc);
        check("fl_failed", Failed, 1);
        check("fl_tries", TriesLeft, 0);
        check("fl_busy", Busy, 0);
        repeat (3) tick();
        check("fl_hold", Failed, 1);
        end_round();
        check("fl_drop", Failed, 0);

        Mode = 2'd2;
        OngoingTimer = 7'd0;
        DataIn = 8'd99;
        Start = 1'b1;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        tick();
        check("sg_loadx", Busy, 1);
        DataIn = 8'd7;
        Go = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            DataIn = 8'($urandom);
            tick();
        end
        Go = 1'b0;
        tick();
        press(3);
        press(5);
        repeat (5) tick();
        check("hold_result", Result, 50);
        end_round();

        start_round(2, 0);
        press(1);
        press(1);
        press(1);
        tick();
        Start = 1'b0;
        tick();
        check("ab_busy", Busy, 0);
        check("ab_tries", TriesLeft, 3);
        check("ab_result", Result, 50);

        start_round(2, 0);
        press(4);
        DataIn = 8'd4;
        Go = 1'b1;
        tick();
        #2 Resetn = 1'b0;
        #1;
        check("mr_busy", Busy, 0);
        check("mr_tries", TriesLeft, 0);
        check("mr_result", Result, 0);
        check("mr_diverr", DivErr, 0);
        Go = 1'b0;
        Start = 1'b0;
        #1 Resetn = 1'b1;
        tick();
        check("mr_idle", Busy, 0);

        last_res = 0;
        for (int n = 0; n < 30; n++) begin
            int m;
            m = $urandom_range(0, 3);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            z = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            ref_eval(m, x, y, z, r, de);
            if ($urandom_range(0, 1) == 1 && r < 128) tgt = r;
            else tgt = $urandom_range(0, 127);
            start_round(m, tgt);
            tries = 3;
            for (int a = 0; a < 3; a++) begin
                if (a > 0) begin
                    x = $urandom_range(0, 255);
                    y = $urandom_range(0, 255);
                    z = $urandom_range(0, 255);
                    ref_eval(m, x, y, z, r, de);
                end
                attempt(x, y, z, dc, cc);
                ok = (r == tgt) && !de;
                if (!ok) tries--;
                check("rn_result", Result, r);
                check("rn_diverr", dc, de);
                check("rn_correct", Correct, ok);
                check("rn_failed", Failed, !ok && tries == 0);
                check("rn_tries", TriesLeft, tries);
                if (ok || tries == 0) break;
            end
            end_round();
            check("rn_idle", Busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
